ram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port synchronous RAM between the instruction-fetch path (read-only) and the data path (load/store) of the CORDIC processor. It accepts one request per cycle via valid/ready handshakes and drives the RAM's `wr_en`/`address`/`data_in` combinationally from the granted request. It routes the RAM's registered read data back to the requester that issued the read, one cycle later. Data port has priority; a wait counter guarantees fetch forward progress.

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/ram_arbiter.sv | 111 +++++++++++
 tb/tb_ram_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the instruction/data RAM arbiter: priority state and grant source.
package ram_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [0:0] {
      PRIO_DM = 1'b0,
      PRIO_IF = 1'b1
   } prio_e;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_IF   = 2'd1,
      SRC_DM   = 2'd2
   } src_e;

endpackage

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data load/store.
// Data side wins conflicts until fetch has been blocked MAX_WAIT cycles in a row.
//
//   state   | meaning
//   PRIO_DM | data port wins a simultaneous request
//   PRIO_IF | fetch starved; fetch wins the next simultaneous request
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_rsp_valid,
   output logic [DATA_W-1:0] if_rsp_data,
   input  logic              dm_req_valid,
   output logic              dm_req_ready,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_rsp_valid,
   output logic [DATA_W-1:0] dm_rsp_data,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   prio_e             prio;
   prio_e             prio_nxt;
   src_e              src;
   logic [WAIT_W-1:0] if_wait;
   logic [WAIT_W-1:0] if_wait_nxt;
   logic              pend_if;
   logic              pend_dm;

   always_comb begin
      src = SRC_NONE;
      if (if_req_valid && dm_req_valid)
         src = (prio == PRIO_IF) ? SRC_IF : SRC_DM;
      else if (if_req_valid)
         src = SRC_IF;
      else if (dm_req_valid)
         src = SRC_DM;
   end

   assign if_req_ready = (src == SRC_IF);
   assign dm_req_ready = (src == SRC_DM);

   // Idle drives zeros so the RAM sees a harmless read of address 0.
   always_comb begin
      ram_wr_en   = 1'b0;
      ram_address = '0;
      ram_data_in = '0;
      case (src)
         SRC_IF: ram_address = if_addr;
         SRC_DM: begin
            ram_wr_en   = dm_we;
            ram_address = dm_addr;
            ram_data_in = dm_wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      if (!if_req_valid || if_req_ready)
         if_wait_nxt = '0;
      else if (if_wait != WAIT_MAX)
         if_wait_nxt = if_wait + WAIT_W'(1);
      else
         if_wait_nxt = if_wait;
   end

   // Switching on the next count (not the current one) hands fetch the very next conflict.
   always_comb begin
      prio_nxt = prio;
      if (prio == PRIO_IF && if_req_ready)
         prio_nxt = PRIO_DM;
      else if (prio == PRIO_DM && if_wait_nxt == WAIT_MAX)
         prio_nxt = PRIO_IF;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio    <= PRIO_DM;
         if_wait <= '0;
         pend_if <= 1'b0;
         pend_dm <= 1'b0;
      end else begin
         prio    <= prio_nxt;
         if_wait <= if_wait_nxt;
         pend_if <= if_req_ready;
         pend_dm <= dm_req_ready && !dm_we;
      end
   end

   assign if_rsp_valid = pend_if;
   assign dm_rsp_valid = pend_dm;
   assign if_rsp_data  = pend_if ? ram_data_out : '0;
   assign dm_rsp_data  = pend_dm ? ram_data_out : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter against a rule-level model with its own RAM image.
module tb_ram_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 4;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req_valid, if_req_ready, if_rsp_valid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rsp_data;
   logic          dm_req_valid, dm_req_ready, dm_we, dm_rsp_valid;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata, dm_rsp_data;
   logic          ram_wr_en;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data_in, ram_data_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
      .ram_wr_en(ram_wr_en), .ram_address(ram_address), .ram_data_in(ram_data_in),
      .ram_data_out(ram_data_out)
   );

   // Environment RAM: registered read, one-cycle latency.
   logic [DW-1:0] mem [0:DEPTH-1];
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_address[9:0]] <= ram_data_in;
      ram_data_out <= mem[ram_address[9:0]];
   end

   // Reference model state
   logic [DW-1:0] ref_mem [0:DEPTH-1];
   bit            m_fetch_turn;
   int            m_blocked;
   bit            m_pif, m_pdm;
   logic [DW-1:0] m_dif, m_ddm;
   int            run;
   logic          obs_if_rdy;
   logic [DW-1:0] obs_dm_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fetch_turn = 1'b0;
      m_blocked    = 0;
      m_pif        = 1'b0;
      m_pdm        = 1'b0;
      m_dif        = '0;
      m_ddm        = '0;
      run          = 0;
   endtask

   task automatic step(input bit iv, input logic [31:0] ia, input bit dv, input bit we,
                       input logic [31:0] da, input logic [31:0] wd);
      bit gif, gdm;
      @(negedge clk);
      if_req_valid = iv;
      if_addr      = ia;
      dm_req_valid = dv;
      dm_we        = we;
      dm_addr      = da;
      dm_wdata     = wd;
      #1;
      gif = iv && (!dv || m_fetch_turn);
      gdm = dv && !gif;
      check("if_ready", if_req_ready, gif);
      check("dm_ready", dm_req_ready, gdm);
      if (gdm) begin
         check("ram_wr_en", ram_wr_en, we);
         check("ram_addr", ram_address, da);
         check("ram_din", ram_data_in, wd);
      end else if (gif) begin
         check("ram_wr_en", ram_wr_en, 0);
         check("ram_addr", ram_address, ia);
      end else begin
         check("ram_wr_en", ram_wr_en, 0);
         check("ram_addr", ram_address, 0);
         check("ram_din", ram_data_in, 0);
      end
      check("if_rsp_valid", if_rsp_valid, m_pif);
      check("if_rsp_data", if_rsp_data, m_pif ? m_dif : 32'h0);
      check("dm_rsp_valid", dm_rsp_valid, m_pdm);
      check("dm_rsp_data", dm_rsp_data, m_pdm ? m_ddm : 32'h0);
      obs_if_rdy  = if_req_ready;
      obs_dm_data = dm_rsp_data;

      if (iv && !if_req_ready) run++;
      else if (iv) begin
         check("if_starve", (run <= MW), 1);
         run = 0;
      end else run = 0;

      m_pif = gif;
      m_dif = ref_mem[ia[9:0]];
      m_pdm = gdm && !we;
      m_ddm = ref_mem[da[9:0]];
      if (gdm && we) ref_mem[da[9:0]] = wd;

      if (iv && !gif) m_blocked = (m_blocked < MW) ? m_blocked + 1 : MW;
      else            m_blocked = 0;
      if (gif)                  m_fetch_turn = 1'b0;
      else if (m_blocked == MW) m_fetch_turn = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      if_req_valid = 1'b0;
      dm_req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_if_rsp_valid", if_rsp_valid, 0);
      check("rst_dm_rsp_valid", dm_rsp_valid, 0);
      check("rst_if_rsp_data", if_rsp_data, 0);
      check("rst_dm_rsp_data", dm_rsp_data, 0);
      check("rst_if_ready", if_req_ready, 0);
      check("rst_dm_ready", dm_req_ready, 0);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = 32'hA5000000 ^ (i * 32'h00010203);
         ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
      end
      rst_n = 1'b0;
      if_req_valid = 1'b0; if_addr = '0;
      dm_req_valid = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      model_reset();
      #2;
      check("rst_if_rsp_valid", if_rsp_valid, 0);
      check("rst_dm_rsp_valid", dm_rsp_valid, 0);
      check("rst_ram_wr_en", ram_wr_en, 0);
      check("rst_ram_addr", ram_address, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // fetch-only stream from addresses 0..3
      for (int i = 0; i < 4; i++) step(1, i, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // store then load of the same address
      step(0, 0, 1, 1, 438, 32'hDEADBEEF);
      step(0, 0, 1, 0, 438, 0);
      step(0, 0, 0, 0, 0, 0);
      check("st_ld_data", obs_dm_data, 32'hDEADBEEF);

      // continuous conflict: four data grants then one fetch grant
      do_reset();
      for (int k = 0; k < 15; k++) begin
         step(1, 100 + k, 1, 0, 200 + k, 0);
         check("conflict_pattern", obs_if_rdy, (k % 5) == 4);
      end
      step(0, 0, 0, 0, 0, 0);

      // single-cycle conflict, then fetch alone
      step(1, 7, 1, 0, 9, 0);
      step(1, 7, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // reset while a load is in flight, after fetch has earned priority
      for (int k = 0; k < 4; k++) step(1, 20, 1, 0, 30 + k, 0);
      do_reset();
      step(1, 21, 1, 0, 31, 0);
      step(0, 0, 0, 0, 0, 0);

      // long idle stretch
      for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, 0);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         bit hot;
         hot = ($urandom_range(0, 1) == 1);
         step($urandom_range(0, 9) < 6,
              hot ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1),
              $urandom_range(0, 9) < 6,
              $urandom_range(0, 1) == 1,
              hot ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1),
              $urandom);
      end
      step(0, 0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
